// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t  : FETCH (request in flight), HOLD (word buffered), KILL (wrong-path request outstanding)
//   ifid_payload_t : instruction + PC+4 pair written into IF/ID
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] next_pc;
  } ifid_payload_t;

  // Word-align a redirect target; the two low bits are don't-care.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter register.
//   clk, rst_n : clock, async active-low reset (resets to RESET_PC)
//   load       : capture d on the rising edge
//   d, q       : next / current PC
module pc_register
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs one outstanding imem request at a
// time and feeds IF/ID with either a valid instruction or a NOP bubble.
//   clk, reset           : clock, async active-low reset
//   stall                : IF/ID must hold
//   redirect, redirect_pc: taken branch/jump and its target
//   imem_req, imem_addr  : fetch request / address (always the PC)
//   imem_ack, imem_rdata : memory response
//   ifid_write           : IF/ID write enable
//   next_PC_out, ir_out  : PC+4 and instruction (or NOP_INSTR / 0 for a bubble)
// Outputs are combinational so IF/ID captures them on the same edge the PC moves.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            ifid_write,
  output logic [XLEN-1:0] next_PC_out,
  output logic [XLEN-1:0] ir_out
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_load;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  ifid_payload_t   payload;

  pc_register u_pc (
    .clk   (clk),
    .rst_n (reset),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc_q)
  );

  // State, instruction buffer and pending redirect target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      buf_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state, PC update and IF/ID output mux.
  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    pc_d       = pc_q;
    buf_d      = buf_q;
    tgt_d      = tgt_q;
    imem_req   = 1'b0;
    ifid_write = redirect | ~stall;
    payload    = '{ir: NOP_INSTR, next_pc: '0};
    pc_plus4   = pc_q + PC_STEP;
    target     = align_pc(redirect_pc);

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          // Without ack the wrong-path request must still be drained.
          if (imem_ack) begin
            pc_load = 1'b1;
            pc_d    = target;
          end else begin
            tgt_d   = target;
            state_d = KILL;
          end
        end else if (imem_ack) begin
          if (!stall) begin
            payload = '{ir: imem_rdata, next_pc: pc_plus4};
            pc_load = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_load = 1'b1;
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall) begin
          payload = '{ir: buf_q, next_pc: pc_plus4};
          pc_load = 1'b1;
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end

      KILL: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // A redirect arriving with the ack beats the stored target.
          pc_load = 1'b1;
          pc_d    = redirect ? target : tgt_q;
          state_d = FETCH;
        end else if (redirect) begin
          tgt_d = target;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    // Outputs held at their reset values while reset is asserted.
    if (!reset) begin
      imem_req   = 1'b0;
      ifid_write = 1'b0;
      payload    = '{ir: NOP_INSTR, next_pc: '0};
    end
  end

  assign imem_addr   = pc_q;
  assign ir_out      = payload.ir;
  assign next_PC_out = payload.next_pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ifid_write;
  logic [31:0] next_PC_out;
  logic [31:0] ir_out;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ifid_write  (ifid_write),
    .next_PC_out (next_PC_out),
    .ir_out      (ir_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural PC plus "what is pending" flags.
  logic [31:0] m_pc;
  bit          m_have_word;
  logic [31:0] m_word;
  bit          m_wrong_path;
  logic [31:0] m_target;

  // Memory responder.
  bit          mem_busy;
  int          mem_wait;
  int          wait_q[$];
  bit          rand_waits;
  bit          prev_pending;
  logic [31:0] prev_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_have_word = 0; m_word = '0; m_wrong_path = 0; m_target = '0;
    mem_busy = 0; mem_wait = 0; prev_pending = 0; prev_addr = '0;
  endtask

  // Compare DUT outputs with the model for this cycle, then advance the model.
  task automatic check_and_advance();
    bit          exp_req, exp_wr, avail;
    logic [31:0] exp_ir, exp_next, tgt;
    exp_req  = !m_have_word;
    exp_wr   = redirect | ~stall;
    avail    = !redirect && (m_have_word || (!m_wrong_path && imem_ack));
    exp_ir   = NOP;
    exp_next = 32'h0;
    if (avail) begin
      exp_ir   = m_have_word ? m_word : imem_rdata;
      exp_next = m_pc + 32'd4;
    end
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_write", 32'(ifid_write), 32'(exp_wr));
    if (exp_wr) begin
      chk("ir_out", ir_out, exp_ir);
      chk("next_PC_out", next_PC_out, exp_next);
    end
    if (prev_pending && imem_req) chk("addr_stable", imem_addr, prev_addr);
    prev_pending = imem_req && !imem_ack;
    prev_addr    = imem_addr;

    tgt = {redirect_pc[31:2], 2'b00};
    if (redirect) begin
      if (m_have_word) begin
        m_have_word = 0; m_pc = tgt;
      end else if (imem_ack) begin
        m_wrong_path = 0; m_pc = tgt;
      end else begin
        m_wrong_path = 1; m_target = tgt;
      end
    end else if (m_have_word) begin
      if (!stall) begin m_have_word = 0; m_pc = m_pc + 32'd4; end
    end else if (imem_ack) begin
      if (m_wrong_path) begin
        m_wrong_path = 0; m_pc = m_target;
      end else if (stall) begin
        m_have_word = 1; m_word = imem_rdata;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock: drive inputs, answer memory, check, advance model.
  task automatic step(input logic s, input logic r, input logic [31:0] rp);
    @(posedge clk);
    #1;
    stall = s; redirect = r; redirect_pc = rp;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        if (wait_q.size() > 0) mem_wait = wait_q.pop_front();
        else mem_wait = rand_waits ? int'($urandom_range(0, 3)) : 0;
      end
      if (mem_wait == 0) begin
        imem_ack = 1'b1; imem_rdata = 32'hA0 + imem_addr; mem_busy = 0;
      end else begin
        imem_ack = 1'b0; imem_rdata = $urandom; mem_wait--;
      end
    end else begin
      imem_ack = 1'b0; imem_rdata = $urandom; mem_busy = 0;
    end
    #1;
    check_and_advance();
  endtask

  // Async reset dropped mid-cycle; outputs must take reset values at once.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b0;
    stall = 0; redirect = 0; imem_ack = 0;
    #1;
    chk({tag, "_rst_req"}, 32'(imem_req), 32'h0);
    chk({tag, "_rst_addr"}, imem_addr, 32'h0);
    chk({tag, "_rst_wr"}, 32'(ifid_write), 32'h0);
    chk({tag, "_rst_ir"}, ir_out, NOP);
    chk({tag, "_rst_next"}, next_PC_out, 32'h0);
    model_reset();
    wait_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    rand_waits = 0;

    // Zero-wait streaming.
    do_reset("init");
    step(0, 0, 0); chk("zw1_ir", ir_out, 32'hA0); chk("zw1_next", next_PC_out, 32'd4);
    chk("zw1_wr", 32'(ifid_write), 32'd1);
    step(0, 0, 0); chk("zw2_ir", ir_out, 32'hA4); chk("zw2_next", next_PC_out, 32'd8);
    chk("zw2_wr", 32'(ifid_write), 32'd1);

    // Two wait cycles at address 0.
    do_reset("wait");
    wait_q.push_back(2);
    step(0, 0, 0); chk("w1_ir", ir_out, NOP); chk("w1_next", next_PC_out, 32'd0);
    step(0, 0, 0); chk("w2_ir", ir_out, NOP); chk("w2_wr", 32'(ifid_write), 32'd1);
    step(0, 0, 0); chk("w3_ir", ir_out, 32'hA0); chk("w3_next", next_PC_out, 32'd4);

    // Stall on the ack cycle, held three more cycles.
    do_reset("stall");
    step(1, 0, 0); chk("st_ack_wr", 32'(ifid_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk("st_hold_wr", 32'(ifid_write), 32'd0);
      chk("st_hold_req", 32'(imem_req), 32'd0);
    end
    step(0, 0, 0); chk("st_rel_ir", ir_out, 32'hA0); chk("st_rel_next", next_PC_out, 32'd4);
    step(0, 0, 0); chk("st_after_addr", imem_addr, 32'd4); chk("st_after_ir", ir_out, 32'hA4);

    // Redirect to 0x40 while the request to 0x8 is unacked.
    do_reset("kill");
    step(0, 0, 0); step(0, 0, 0);
    wait_q.push_back(3);
    step(0, 1, 32'h40); chk("k_rd_wr", 32'(ifid_write), 32'd1); chk("k_rd_ir", ir_out, NOP);
    chk("k_rd_addr", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0); chk("k_addr", imem_addr, 32'h8); chk("k_ir", ir_out, NOP);
    end
    step(0, 0, 0); chk("k_new_addr", imem_addr, 32'h40); chk("k_new_ir", ir_out, 32'hE0);
    chk("k_new_next", next_PC_out, 32'h44);

    // Redirect with stall while a word is buffered.
    do_reset("hold");
    step(1, 0, 0);
    step(1, 1, 32'h40); chk("h_wr", 32'(ifid_write), 32'd1); chk("h_ir", ir_out, NOP);
    chk("h_next", next_PC_out, 32'd0);
    step(0, 0, 0); chk("h_addr", imem_addr, 32'h40); chk("h_ir2", ir_out, 32'hE0);

    // PC wrap at the top of the address space.
    do_reset("wrap");
    step(0, 1, 32'hFFFF_FFFD);
    step(0, 0, 0); chk("wr_addr", imem_addr, 32'hFFFF_FFFC); chk("wr_next", next_PC_out, 32'd0);
    chk("wr_ir", ir_out, 32'h0000_009C);
    step(0, 0, 0); chk("wr_addr0", imem_addr, 32'h0); chk("wr_ir0", ir_out, 32'hA0);

    // Reset in the middle of an outstanding request.
    do_reset("mid");
    step(0, 0, 0); step(0, 0, 0);
    wait_q.push_back(5);
    step(0, 0, 0); chk("mid_req", 32'(imem_req), 32'd1);
    do_reset("mid2");
    step(0, 0, 0); chk("mid_after_ir", ir_out, 32'hA0);

    // Randomised traffic.
    rand_waits = 1;
    for (int i = 0; i < 3000; i++) begin
      logic s, r;
      s = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 9) == 0);
      step(s, r, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
